// File: rtl/obj_slot_pkg.sv
// Shared types for the object slot manager.
//   coord_t        : unsigned pixel coordinate
//   xy_t           : packed {x, y} pair, stored in the respawn FIFO
//   refill_state_t : batch refill FSM states
//   MODE_*         : refill mode selectors
package obj_slot_pkg;
   localparam int COORD_WIDTH = 11;

   typedef logic [COORD_WIDTH-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } xy_t;

   typedef enum logic {IDLE, REFILL} refill_state_t;

   localparam int MODE_BATCH   = 0;
   localparam int MODE_TRICKLE = 1;
endpackage

// File: rtl/respawn_fifo.sv
// Synchronous FIFO of respawn coordinates, first-word-fall-through read.
//   clk, rst     : clock, asynchronous active-high reset
//   push, push_data : write request; dropped when full
//   pop, pop_data   : read request; pop_data is the current head
//   full, empty  : occupancy flags
//   overflow     : sticky, set by a dropped push, cleared only by reset
module respawn_fifo
   import obj_slot_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  xy_t  push_data,
   input  logic pop,
   output xy_t  pop_data,
   output logic full,
   output logic empty,
   output logic overflow
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   xy_t mem [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          do_push, do_pop;

   always_comb begin
      full    = (cnt_q == (AW+1)'(DEPTH));
      empty   = (cnt_q == '0);
      do_push = push && !full;
      do_pop  = pop && !empty;
      wr_d    = wr_q + AW'(do_push);
      rd_d    = rd_q + AW'(do_pop);
      cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      ovf_d   = ovf_q | (push && full);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= push_data;
   end

   assign pop_data = mem[rd_q];
   assign overflow = ovf_q;
endmodule

// File: rtl/object_slot_manager.sv
// Tracks N collectible objects: position and active flag per slot, retires a
// slot on an accepted clamp hit, queues a clamped random respawn coordinate per
// hit and repopulates slots in batch (all cleared) or trickle (per-slot timer)
// mode.
//   clk, reset            : clock, asynchronous active-high reset
//   start_of_frame        : frame tick, drives trickle countdowns
//   hit_valid/hit_index   : collision report from the clamp
//   rand_x/rand_y         : random respawn coordinate, sampled on accepted hit
//   refill_enable         : batch refill permission
//   top_left_x/y          : per-slot position
//   draw_request          : per-slot active flag
//   active_count          : popcount of draw_request
//   hit_accept            : pulse, a hit retired a slot
//   all_cleared           : pulse, last active slot retired
//   fifo_overflow         : sticky, respawn coordinate dropped
module object_slot_manager
   import obj_slot_pkg::*;
#(
   parameter int N_SLOTS        = 10,
   parameter int COORD_W        = COORD_WIDTH,
   parameter int FIFO_DEPTH     = 16,
   parameter int MODE           = MODE_BATCH,
   parameter int RESPAWN_FRAMES = 60,
   parameter int X_MAX          = 639,
   parameter int Y_MAX          = 479,
   parameter int OBJ_W          = 32,
   parameter int OBJ_H          = 32,
   parameter logic [N_SLOTS-1:0] INIT_MASK = 10'h3da,
   // slot 0 is the rightmost (least significant) element
   parameter logic [N_SLOTS-1:0][COORD_W-1:0] INIT_X =
      {11'd550, 11'd440, 11'd480, 11'd370, 11'd330, 11'd170, 11'd200, 11'd140, 11'd80, 11'd70},
   parameter logic [N_SLOTS-1:0][COORD_W-1:0] INIT_Y =
      {11'd180, 11'd180, 11'd380, 11'd170, 11'd330, 11'd410, 11'd200, 11'd160, 11'd320, 11'd200}
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start_of_frame,
   input  logic                              hit_valid,
   input  logic [$clog2(N_SLOTS)-1:0]        hit_index,
   input  logic [COORD_W-1:0]                rand_x,
   input  logic [COORD_W-1:0]                rand_y,
   input  logic                              refill_enable,
   output logic [N_SLOTS-1:0][COORD_W-1:0]   top_left_x,
   output logic [N_SLOTS-1:0][COORD_W-1:0]   top_left_y,
   output logic [N_SLOTS-1:0]                draw_request,
   output logic [$clog2(N_SLOTS+1)-1:0]      active_count,
   output logic                              hit_accept,
   output logic                              all_cleared,
   output logic                              fifo_overflow
);
   localparam int IW = $clog2(N_SLOTS);
   localparam int CW = $clog2(N_SLOTS+1);
   localparam coord_t X_LIM = coord_t'(X_MAX - OBJ_W);
   localparam coord_t Y_LIM = coord_t'(Y_MAX - OBJ_H);

   function automatic logic [CW-1:0] popcnt(input logic [N_SLOTS-1:0] v);
      popcnt = '0;
      for (int i = 0; i < N_SLOTS; i++) popcnt = popcnt + CW'(v[i]);
   endfunction

   logic [N_SLOTS-1:0][COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [N_SLOTS-1:0]              draw_q, draw_d, pend_q, pend_d, hit_vec;
   logic [N_SLOTS-1:0][7:0]         cnt_q, cnt_d;
   refill_state_t                   state_q, state_d;
   logic [IW-1:0]                   idx_q, idx_d;
   logic [CW-1:0]                   active_q, active_d;
   logic                            acc_q, acc_d, clr_q, clr_d;
   logic                            hit_ok, pop, found;
   xy_t                             push_data, head;
   logic                            fifo_full, fifo_empty;

   // Out-of-range indices never match a slot, so they fall out naturally.
   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < N_SLOTS; i++)
         hit_vec[i] = hit_valid && (hit_index == IW'(i)) && draw_q[i];
      hit_ok      = |hit_vec;
      push_data.x = (rand_x > X_LIM) ? X_LIM : rand_x;
      push_data.y = (rand_y > Y_LIM) ? Y_LIM : rand_y;
   end

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      draw_d  = draw_q & ~hit_vec;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      state_d = state_q;
      idx_d   = idx_q;
      pop     = 1'b0;
      found   = 1'b0;
      if (MODE == MODE_TRICKLE) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            if (start_of_frame && cnt_q[i] != 8'd0) cnt_d[i] = cnt_q[i] - 8'd1;
            if (hit_vec[i]) begin
               cnt_d[i]  = 8'(RESPAWN_FRAMES);
               pend_d[i] = 1'b1;
            end
            // first eligible slot claims the single pop; it waits if FIFO empty
            if (!found && pend_q[i] && cnt_q[i] == 8'd0 && !draw_q[i]) begin
               found = 1'b1;
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  x_d[i]    = head.x;
                  y_d[i]    = head.y;
                  draw_d[i] = 1'b1;
                  pend_d[i] = 1'b0;
               end
            end
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (draw_q == '0 && refill_enable) begin
                  state_d = REFILL;
                  idx_d   = '0;
               end
            end
            REFILL: begin
               pop = !fifo_empty;
               for (int i = 0; i < N_SLOTS; i++) begin
                  if (idx_q == IW'(i)) begin
                     x_d[i]    = fifo_empty ? INIT_X[i] : head.x;
                     y_d[i]    = fifo_empty ? INIT_Y[i] : head.y;
                     draw_d[i] = 1'b1;
                  end
               end
               if (idx_q == IW'(N_SLOTS-1)) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      active_d = popcnt(draw_d);
      acc_d    = hit_ok;
      clr_d    = (draw_q != '0) && (draw_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q      <= INIT_X;
         y_q      <= INIT_Y;
         draw_q   <= INIT_MASK;
         pend_q   <= '0;
         cnt_q    <= '0;
         state_q  <= IDLE;
         idx_q    <= '0;
         active_q <= popcnt(INIT_MASK);
         acc_q    <= 1'b0;
         clr_q    <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         draw_q   <= draw_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         idx_q    <= idx_d;
         active_q <= active_d;
         acc_q    <= acc_d;
         clr_q    <= clr_d;
      end
   end

   respawn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (hit_ok),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .overflow  (fifo_overflow)
   );

   assign top_left_x   = x_q;
   assign top_left_y   = y_q;
   assign draw_request = draw_q;
   assign active_count = active_q;
   assign hit_accept   = acc_q;
   assign all_cleared  = clr_q;
endmodule

// File: doc/object_slot_manager.md
Name: object_slot_manager

Overview:
- Parametrised manager for N collectible on-screen objects (vaccines, bonuses).
- Holds each slot's top-left position and active flag, and retires a slot when the clamp reports a hit on it.
- Captures a random respawn coordinate per hit into a FIFO, then repopulates slots in batch or trickle mode.
- Sits between the collision logic / random generator and the per-slot bitmap drawers.

Parameters:
N_SLOTS, 10, number of object slots (2..16)
COORD_W, 11, coordinate width, unsigned pixels
FIFO_DEPTH, 16, respawn-coordinate FIFO depth, power of 2
MODE, 0, 0 = batch refill when all slots cleared; 1 = trickle per-slot respawn
RESPAWN_FRAMES, 60, trickle mode: frames a slot stays dark before respawn (1..255)
X_MAX, 639, rightmost pixel
Y_MAX, 479, bottom pixel
OBJ_W, 32, object width
OBJ_H, 32, object height
INIT_MASK, 10'h3da, reset active mask, bit i = slot i
INIT_X, {70,80,140,200,170,330,370,480,440,550}, reset X per slot
INIT_Y, {200,320,160,200,410,330,170,380,180,180}, reset Y per slot

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_of_frame  in  1  one-cycle pulse per frame
hit_valid  in  1  clamp collided with an object this cycle
hit_index  in  $clog2(N_SLOTS)  slot that was hit
rand_x  in  COORD_W  random X, sampled on an accepted hit
rand_y  in  COORD_W  random Y, sampled on an accepted hit
refill_enable  in  1  batch refill permitted (clamp in circular movement)
top_left_x  out  N_SLOTS x COORD_W  per-slot X
top_left_y  out  N_SLOTS x COORD_W  per-slot Y
draw_request  out  N_SLOTS  per-slot active flag
active_count  out  $clog2(N_SLOTS+1)  popcount of draw_request
hit_accept  out  1  pulse: hit retired a slot
all_cleared  out  1  pulse: active_count went from 1 to 0
fifo_overflow  out  1  sticky: push dropped because FIFO was full

Behaviour:
- Reset, asynchronous and immediate:
  - positions = INIT_X/INIT_Y; draw_request = INIT_MASK; active_count = popcount(INIT_MASK).
  - FIFO empty; trickle counters = 0; FSM = IDLE.
  - hit_accept, all_cleared and fifo_overflow = 0.
- Hit accept:
  - A hit is accepted when hit_valid, hit_index < N_SLOTS and draw_request[hit_index] = 1.
  - Accepted hit: draw_request[hit_index] clears next cycle; hit_accept pulses that same next cycle.
  - Accepted hit also pushes the clamped coordinate: x = min(rand_x, X_MAX-OBJ_W), y = min(rand_y, Y_MAX-OBJ_H).
  - Hit on an inactive or out-of-range slot is ignored: no push, no pulse.
- FIFO:
  - Push when full is dropped and sets fifo_overflow, cleared only by reset.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Batch mode (MODE=0) FSM:
  - IDLE -> REFILL when draw_request == 0 and refill_enable = 1.
  - REFILL visits slot i = 0..N_SLOTS-1, one slot per cycle.
  - Per slot: if FIFO is non-empty, pop and load the popped coordinate; otherwise load INIT_X[i]/INIT_Y[i]. Set draw_request[i] = 1.
  - After slot N_SLOTS-1 -> IDLE. Latency: N_SLOTS cycles.
  - A hit during REFILL on an already-loaded slot is accepted normally.
  - refill_enable is ignored once REFILL has started.
- Trickle mode (MODE=1):
  - An accepted hit loads counter[i] = RESPAWN_FRAMES.
  - Each start_of_frame decrements every non-zero counter.
  - A slot whose counter is 0, that is inactive, and was dark from a hit (pending bit set) respawns: pop FIFO, load position, set draw_request.
  - At most one respawn per cycle, lowest index first. If the FIFO is empty, the slot waits with pending still set.
  - refill_enable is ignored; the FSM stays IDLE.
- all_cleared pulses once per transition to zero, in both modes.
- active_count is registered and is consistent with draw_request on the same cycle.
- Widths: clamp comparisons are unsigned COORD_W. Trickle counters are 8 bits.

Decomposition:
- Package obj_slot_pkg holds:
  - typedef coord_t (COORD_W);
  - typedef xy_t struct {x, y};
  - enum refill_state_t {IDLE, REFILL};
  - mode constants MODE_BATCH and MODE_TRICKLE.
- Sub-module respawn_fifo: synchronous FIFO of xy_t with push, pop, full, empty and overflow outputs.

Test Plan:
- Reset -> draw_request = 10'h3da, top_left_x[0] = 70, top_left_y[4] = 410, active_count = 7.
- hit_valid, hit_index = 1, rand = (700, 100) -> next cycle draw_request[1] = 0, hit_accept = 1; FIFO head = (607, 100).
- hit on slot 0 (inactive in INIT_MASK) and hit_index = 12 -> no change, no push, hit_accept = 0.
- Batch: clear all 7 active slots with 7 hits, then refill_enable = 1 -> all_cleared pulses. After 10 cycles all slots are active: slots 0..6 get the FIFO coordinates in push order, slots 7..9 get INIT_X/INIT_Y.
- Trickle, RESPAWN_FRAMES = 3: hit slot 3 -> still dark after 2 frames, active within 1 cycle after the 3rd start_of_frame, at the pushed coordinate.
- 17 hits with FIFO_DEPTH = 16 and no pops -> fifo_overflow = 1 and stays set until reset.
